// File: rtl/lfsr_seq_if.sv
// lfsr_seq_if: command/response bus between a command source and the lfsr sequencer
interface lfsr_seq_if #(parameter int CNT_W = 9);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [7:0]       cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             rsp_valid;
    logic             rsp_err;
    logic             rsp_wrapped;
    logic [7:0]       state;
    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count,
        input  cmd_ready, rsp_valid, rsp_err, rsp_wrapped, state
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count,
        output cmd_ready, rsp_valid, rsp_err, rsp_wrapped, state
    );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command sequencer owning the lfsr state and walking it N steps per command
module lfsr_seq_ctrl #(
    parameter int         CNT_W    = 9,
    parameter logic [7:0] RST_SEED = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_seq_if.slave   bus,
    output logic [7:0]  lfsr_in,
    output logic        lfsr_np,
    output logic        lfsr_tap_en,
    output logic [7:0]  lfsr_tap_data,
    input  logic [7:0]  lfsr_out
);
    typedef enum logic [1:0] {IDLE, TAPS, STEP, RESP} fsm_t;
    fsm_t             fsm;
    logic [7:0]       state_q;
    logic [7:0]       start_q;
    logic [CNT_W-1:0] remaining;
    logic             taps_valid;
    logic             dir_q;
    logic             err_q;
    logic             wrap_q;
    logic             tap_en_q;
    logic [7:0]       tap_data_q;
    assign bus.cmd_ready   = fsm == IDLE;
    assign bus.rsp_valid   = fsm == RESP;
    assign bus.rsp_err     = bus.rsp_valid & err_q;
    assign bus.rsp_wrapped = bus.rsp_valid & wrap_q;
    assign bus.state       = state_q;
    assign lfsr_in         = state_q;
    assign lfsr_np         = dir_q;
    assign lfsr_tap_en     = tap_en_q;
    assign lfsr_tap_data   = tap_data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            state_q    <= RST_SEED;
            start_q    <= '0;
            remaining  <= '0;
            taps_valid <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            tap_en_q   <= 1'b0;
            tap_data_q <= '0;
        end else begin
            tap_en_q <= 1'b0;
            case (fsm)
                IDLE: if (bus.cmd_valid) begin
                    err_q  <= 1'b0;
                    wrap_q <= 1'b0;
                    case (bus.cmd_op)
                        2'd0: begin
                            tap_en_q   <= 1'b1;
                            tap_data_q <= bus.cmd_data;
                            fsm        <= TAPS;
                        end
                        2'd1: begin
                            state_q <= bus.cmd_data;
                            fsm     <= RESP;
                        end
                        2'd2: begin
                            if (!taps_valid) begin
                                err_q <= 1'b1;
                                fsm   <= RESP;
                            end else if (bus.cmd_count == '0) begin
                                fsm <= RESP;
                            end else begin
                                dir_q     <= bus.cmd_dir;
                                start_q   <= state_q;
                                remaining <= bus.cmd_count;
                                fsm       <= STEP;
                            end
                        end
                        default: begin
                            err_q <= 1'b1;
                            fsm   <= RESP;
                        end
                    endcase
                end
                TAPS: begin
                    taps_valid <= 1'b1;
                    fsm        <= RESP;
                end
                STEP: begin
                    state_q   <= lfsr_out;
                    remaining <= remaining - CNT_W'(1);
                    if (lfsr_out == start_q) wrap_q <= 1'b1;
                    if (remaining == CNT_W'(1)) fsm <= RESP;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: scoreboard bench with an lfsr stand-in and a walk-level reference model
module tb_lfsr_seq_ctrl;
    typedef struct {
        int         cyc;
        logic       err;
        logic       wrap;
        logic [7:0] st;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lfsr_in;
    logic       lfsr_np;
    logic       lfsr_tap_en;
    logic [7:0] lfsr_tap_data;
    logic [7:0] lfsr_out;
    logic [7:0] env_taps = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       sb[$];
    logic [7:0] m_state = 8'h01;
    logic [7:0] m_taps = 8'h00;
    logic       m_tv = 1'b0;
    lfsr_seq_if #(.CNT_W(9)) ifc();
    lfsr_seq_ctrl #(.CNT_W(9), .RST_SEED(8'h01)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc),
        .lfsr_in(lfsr_in),
        .lfsr_np(lfsr_np),
        .lfsr_tap_en(lfsr_tap_en),
        .lfsr_tap_data(lfsr_tap_data),
        .lfsr_out(lfsr_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Forward step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] fwd(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction
    // Backward step: the predecessor is whichever state steps forward onto s.
    function automatic logic [7:0] bwd(input logic [7:0] s, input logic [7:0] t);
        logic [7:0] r;
        r = s;
        for (int p = 0; p < 256; p++) if (fwd(8'(p), t) == s) r = 8'(p);
        return r;
    endfunction
    always @(posedge clk) if (lfsr_tap_en) env_taps <= lfsr_tap_data;
    assign lfsr_out = lfsr_np ? fwd(lfsr_in, env_taps) : bwd(lfsr_in, env_taps);
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && ifc.rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_err", ifc.rsp_err, e.err);
                check("rsp_wrapped", ifc.rsp_wrapped, e.wrap);
                check("rsp_state", ifc.state, e.st);
            end
        end
    end
    task automatic finish_cmd(input int lat, input logic tap, input logic [7:0] d);
        int lo;
        lo = 0;
        @(negedge clk);
        if (tap) begin
            check("tap_en_pulse", lfsr_tap_en, 1'b1);
            check("tap_data", lfsr_tap_data, d);
        end
        while (!ifc.cmd_ready && lo < 1000) begin
            lo++;
            if (tap && lo == 2) check("tap_en_drop", lfsr_tap_en, 1'b0);
            @(negedge clk);
        end
        check("busy_cycles", lo, lat);
    endtask
    task automatic issue(input logic [1:0] op, input logic dir, input logic [7:0] data,
                         input logic [8:0] n, input logic done);
        exp_t e;
        logic [7:0] s;
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!ifc.cmd_ready && w < 2000) begin
            w++;
            @(negedge clk);
        end
        check("ready_before_cmd", ifc.cmd_ready, 1'b1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_dir   = dir;
        ifc.cmd_data  = data;
        ifc.cmd_count = n;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        e.err  = 1'b0;
        e.wrap = 1'b0;
        lat    = 1;
        case (op)
            2'd0: begin
                m_taps = data;
                m_tv   = 1'b1;
                lat    = 2;
            end
            2'd1: m_state = data;
            2'd2: begin
                if (!m_tv) e.err = 1'b1;
                else if (n != 0) begin
                    s = m_state;
                    for (int i = 0; i < int'(n); i++) begin
                        s = dir ? fwd(s, m_taps) : bwd(s, m_taps);
                        if (s == m_state) e.wrap = 1'b1;
                    end
                    m_state = s;
                    lat = int'(n) + 1;
                end
            end
            default: e.err = 1'b1;
        endcase
        e.st  = m_state;
        e.cyc = cyc + lat - 1;
        sb.push_back(e);
        if (done) finish_cmd(lat, op == 2'd0, data);
    endtask
    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'd0;
        ifc.cmd_dir   = 1'b0;
        ifc.cmd_data  = 8'h00;
        ifc.cmd_count = 9'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", ifc.state, 8'h01);
        check("rst_ready", ifc.cmd_ready, 1'b1);
        check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check("rst_tap_en", lfsr_tap_en, 1'b0);
        check("rst_tap_data", lfsr_tap_data, 8'h00);
        check("rst_np", lfsr_np, 1'b1);
        issue(2'd2, 1'b1, 8'h00, 9'd4, 1'b1);
        check("no_taps_state", ifc.state, 8'h01);
        issue(2'd0, 1'b0, 8'hB8, 9'd0, 1'b1);
        issue(2'd1, 1'b0, 8'h01, 9'd0, 1'b1);
        issue(2'd2, 1'b1, 8'h00, 9'd4, 1'b1);
        check("fwd4_state", ifc.state, 8'h11);
        issue(2'd2, 1'b0, 8'h00, 9'd4, 1'b1);
        check("back4_state", ifc.state, 8'h01);
        issue(2'd1, 1'b0, 8'h01, 9'd0, 1'b1);
        issue(2'd2, 1'b1, 8'h00, 9'd255, 1'b1);
        check("walk255_state", ifc.state, 8'h01);
        issue(2'd2, 1'b1, 8'h00, 9'd0, 1'b1);
        issue(2'd3, 1'b1, 8'h00, 9'd3, 1'b1);
        // Hold a SEED on the bus while a walk is running; it must be ignored.
        issue(2'd2, 1'b1, 8'h00, 9'd20, 1'b0);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'd1;
        ifc.cmd_data  = 8'h5A;
        repeat (10) @(negedge clk);
        ifc.cmd_valid = 1'b0;
        for (int w = 0; w < 100 && !ifc.cmd_ready; w++) @(negedge clk);
        check("hold_ready", ifc.cmd_ready, 1'b1);
        check("hold_state", ifc.state, m_state);
        issue(2'd2, 1'b0, 8'h00, 9'd200, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        m_state = 8'h01;
        m_tv    = 1'b0;
        @(negedge clk);
        check("midrst_state", ifc.state, 8'h01);
        check("midrst_ready", ifc.cmd_ready, 1'b1);
        repeat (5) @(negedge clk);
        issue(2'd2, 1'b1, 8'h00, 9'd5, 1'b1);
        issue(2'd0, 1'b0, {1'b1, 7'($urandom)}, 9'd0, 1'b1);
        repeat (25) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0) issue(op, 1'b0, {1'b1, 7'($urandom)}, 9'd0, 1'b1);
            else issue(op, 1'($urandom), 8'($urandom), 9'($urandom_range(0, 60)), 1'b1);
        end
        issue(2'd2, 1'($urandom), 8'h00, 9'd511, 1'b1);
        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
